// File: rtl/morph_filter_3x3.sv
// ============================================================================
// morph_filter_3x3 : streaming 3x3 binary dilation/erosion/bypass filter
// Rev 1.0
// ============================================================================
`default_nettype none

module morph_filter_3x3 #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CW    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_mode,
  input  logic [8:0] i_se,
  input  logic       i_valid,
  input  logic       i_sof,
  input  logic       i_pixel,
  output logic       o_in_ready,
  output logic       o_valid,
  output logic       o_pixel,
  output logic       o_sof,
  output logic       o_eof,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  localparam logic [1:0]    MODE_DIL = 2'b01;
  localparam logic [1:0]    MODE_ERO = 2'b10;
  localparam logic [CW-1:0] X_LAST   = CW'(IMG_W - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(IMG_H - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [1:0]    mode_q, mode_d;
  logic [8:0]    se_q, se_d;
  logic [8:0]    win_q, win_d;
  logic [IMG_W-1:0] lb1_q, lb2_q;
  logic          valid_q, pixel_q, sof_q, eof_q;

  logic          w_accept, w_start, w_step, w_emit, w_pix_in, w_res;
  logic          w_up1, w_up2, w_out_first, w_out_last;
  logic [CW-1:0] w_wx;
  logic [8:0]    w_inmask;

  assign o_in_ready = (state_q != S_FLUSH);
  assign o_busy     = (state_q != S_IDLE);
  assign o_valid    = valid_q;
  assign o_pixel    = pixel_q;
  assign o_sof      = sof_q;
  assign o_eof      = eof_q;

  assign w_accept = i_valid && o_in_ready;
  assign w_start  = w_accept && i_sof;
  assign w_step   = w_start || (state_q == S_FLUSH) ||
                    (w_accept && ((state_q == S_FILL) || (state_q == S_RUN)));
  assign w_emit   = w_step && !w_start &&
                    ((state_q == S_RUN) || (state_q == S_FLUSH) ||
                     ((state_q == S_FILL) && (x_q == ONE) && (y_q == ONE)));
  assign w_pix_in = (state_q == S_FLUSH) ? 1'b0 : i_pixel;
  assign w_wx     = w_start ? '0 : x_q;
  assign w_up1    = lb1_q[w_wx];
  assign w_up2    = lb2_q[w_wx];

  assign w_out_first = (ox_q == '0) && (oy_q == '0);
  assign w_out_last  = (ox_q == X_LAST) && (oy_q == Y_LAST);

  // Window taps falling outside the image, relative to the output pixel.
  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      assign w_inmask[3*r+c] = !((r == 0) && (oy_q == '0))     &&
                               !((r == 2) && (oy_q == Y_LAST)) &&
                               !((c == 0) && (ox_q == '0))     &&
                               !((c == 2) && (ox_q == X_LAST));
    end
  end

  always_comb begin
    win_d = win_q;
    if (w_step) begin
      win_d = {w_pix_in, win_q[8:7], w_up1, win_q[5:4], w_up2, win_q[2:1]};
    end
  end

  always_comb begin
    case (mode_q)
      MODE_DIL: w_res = |(win_d & se_q & w_inmask);
      MODE_ERO: w_res = &(win_d | ~se_q | ~w_inmask);
      default:  w_res = win_d[4];
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    mode_d  = mode_q;
    se_d    = se_q;
    if (w_start) begin
      mode_d  = i_mode;
      se_d    = i_se;
      x_d     = ONE;
      y_d     = '0;
      ox_d    = '0;
      oy_d    = '0;
      state_d = S_FILL;
    end else if (w_step) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q != Y_LAST) y_d = y_q + ONE;
      end else begin
        x_d = x_q + ONE;
      end
      if (w_emit) begin
        if (ox_q == X_LAST) begin
          ox_d = '0;
          oy_d = (oy_q == Y_LAST) ? '0 : oy_q + ONE;
        end else begin
          ox_d = ox_q + ONE;
        end
      end
      case (state_q)
        S_FILL:  if ((x_q == ONE) && (y_q == ONE)) state_d = S_RUN;
        S_RUN:   if ((x_q == X_LAST) && (y_q == Y_LAST)) state_d = S_FLUSH;
        S_FLUSH: if (w_out_last) state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      mode_q  <= '0;
      se_q    <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      pixel_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      mode_q  <= mode_d;
      se_q    <= se_d;
      win_q   <= win_d;
      valid_q <= w_emit;
      pixel_q <= w_emit && w_res;
      sof_q   <= w_emit && w_out_first;
      eof_q   <= w_emit && w_out_last;
    end
  end

  // Line buffers are not reset; stale contents only reach masked taps.
  always_ff @(posedge clk) begin
    if (w_step) begin
      lb1_q[w_wx] <= w_pix_in;
      lb2_q[w_wx] <= w_up1;
    end
  end

endmodule

`default_nettype wire

// File: doc/morph_filter_3x3.md
Name: morph_filter_3x3

Overview:
- Streaming 3x3 binary morphology filter for the VGA processing chain.
- Generalises the fixed dilation stage:
  - image size is parametrised;
  - mode is selectable per frame: bypass, dilation or erosion;
  - structuring element is a programmable 9-bit mask;
  - image borders are handled explicitly;
  - an end-of-frame flush is generated internally.
- Sits between binary_convert and the VGA output mux, clocked by the VGA pixel clock.

Parameters:
- IMG_W, 640, pixels per line (≥4).
- IMG_H, 480, lines per frame (≥3).
- CW, 10, column/row counter width; must satisfy 2^CW ≥ max(IMG_W, IMG_H).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-high; clears all state.
- i_mode  in  2  00 bypass, 01 dilation, 10 erosion, 11 treated as bypass; sampled on accepted SOF.
- i_se  in  9  structuring-element mask; bit 3*r+c = window row r, column c; bit 4 = centre; sampled on accepted SOF.
- i_valid  in  1  input pixel valid.
- i_sof  in  1  qualifies the first pixel (0,0) of a frame.
- i_pixel  in  1  binary input pixel, raster order.
- o_in_ready  out  1  block accepts input; transfer occurs when i_valid & o_in_ready.
- o_valid  out  1  output pixel valid; single-cycle pulse per pixel, no backpressure.
- o_pixel  out  1  filtered pixel.
- o_sof  out  1  asserted with output pixel (0,0).
- o_eof  out  1  asserted with output pixel (IMG_W-1, IMG_H-1).
- o_busy  out  1  high in FILL, RUN and FLUSH.

Behaviour:
- Reset values: o_valid=0, o_pixel=0, o_sof=0, o_eof=0, o_busy=0, o_in_ready=1. Line buffers need not be cleared; border masking makes stale contents invisible.
- Storage: two IMG_W-bit line buffers plus a 3x3 shift window.
- Input index k = y*IMG_W + x.

State machine:
- IDLE
  - o_in_ready=1.
  - Accepted pixels without i_sof are dropped.
  - Accepted pixel with i_sof: latch i_mode and i_se, write pixel, go to FILL.
- FILL
  - Accept inputs k = 1..IMG_W; no output.
  - After input k = IMG_W+1 is accepted (i.e. the (IMG_W+2)-th pixel), go to RUN.
- RUN
  - Each accepted input k produces output index k-(IMG_W+1), registered on the next cycle (o_valid one cycle after the handshake).
  - After input IMG_W*IMG_H-1 is accepted, go to FLUSH.
- FLUSH
  - o_in_ready=0.
  - Emit the remaining IMG_W+1 outputs on consecutive cycles, with absent input treated as out-of-image.
  - After o_eof, go to IDLE.

Output count and latency:
- Exactly IMG_W*IMG_H outputs per frame, in raster order.
- o_sof is on the first output; o_eof is on the last.

Window operation:
- Out-of-image neighbours (x-1<0, x+1≥IMG_W, y-1<0, y+1≥IMG_H) read 0 for dilation and 1 for erosion.
- Dilation: o_pixel = OR over set bits of se of the window pixel.
- Erosion: o_pixel = AND over set bits of se of the window pixel.
- Bypass: o_pixel = centre pixel. Latency is identical to the filtered modes.
- se = 0: dilation outputs 0, erosion outputs 1.

Boundary rules:
- i_sof accepted in FILL or RUN:
  - abort the current frame with no o_eof;
  - restart as a new frame with this pixel as (0,0), relatching mode and se.
- i_mode and i_se changes mid-frame have no effect.
- Gaps in i_valid stall the pipeline. No output is produced without an input in FILL/RUN.
- rst mid-frame: immediate return to IDLE with reset output values.

Test Plan:
- IMG_W=4, IMG_H=3, dilation, se=9'h1FF, single 1 at (1,1), rest 0:
  - outputs: rows 0-2 columns 0-2 = 1, column 3 = 0;
  - exactly 12 o_valid pulses;
  - o_sof on the first, o_eof on the 12th;
  - o_in_ready low for 5 cycles during FLUSH.
- Same frame, erosion, all-ones input, se=9'h1FF:
  - output all 1s (borders neutral).
  - Repeat with a single 0 at (2,1): output 0 at (1..3, 0..2) neighbourhood, 1 elsewhere.
- Bypass with a random 4x3 frame:
  - output equals input;
  - the first o_valid appears one cycle after the handshake of input k=5.
- Dilation, se=9'h010 (centre only): output equals input. se=0 in erosion mode: all outputs 1.
- i_valid toggled with 50% random gaps: output sequence identical to the gap-free run; no o_valid while starved in RUN.
- Abort and reset:
  - i_sof reasserted at input k=7: no o_eof for the first frame; the second frame completes with 12 outputs and the new mode/se.
  - rst pulsed in RUN: all outputs 0 next cycle, o_in_ready=1, state IDLE.
